stopwatch_bcd: RTL
==================

# stopwatch_bcd

Four-digit BCD stopwatch (000.0–999.9 s) driven by two push-buttons; it produces the 16-bit `text` word consumed directly by the four-digit seven-segment display block's `text` input. It contains:
- a per-button synchronizer, debouncer and press detector;
- a run/stop control register;
- a 0.1 s tick prescaler;
- a cascaded four-digit BCD counter with wrap flag.

## Interface
- `TICK_DIV`, 10_000_000: clocks per 0.1 s tick (100 MHz clk); ≥2.
- `DB_CYCLES`, 1_000_000: clocks a synchronized button level must stay stable before it is accepted (10 ms); ≥2.
- `clk`  in  1  system clock; all state updates on rising edge.
- `arst`  in  1  reset, synchronous, active-high.
- `btn_ss`  in  1  start/stop button, asynchronous raw level, high = pressed.
- `btn_clr`  in  1  clear button, asynchronous raw level, high = pressed.
- `text`  out  16  BCD digits: [15:12] hundreds s, [11:8] tens s, [7:4] units s, [3:0] tenths s.
- `running`  out  1  1 while counting.
- `ovf`  out  1  one-cycle pulse on wrap 999.9→000.0.

## Operation
- **Per-button front end** (identical for `btn_ss` and `btn_clr`):
  - Two-flop synchronizer `s1 <= btn; s2 <= s1`.
  - Stable register `stb` and counter `dcnt` (width `$clog2(DB_CYCLES)`):
    - If `s2 == stb`: `dcnt <= 0`.
    - Else if `dcnt == DB_CYCLES-1`: `stb <= s2`, `dcnt <= 0`.
    - Else: `dcnt <= dcnt+1`.
  - Press pulse `p` (combinational) = `s2 & ~stb & (dcnt == DB_CYCLES-1)`, i.e. high in the cycle before `stb` rises.
  - Release is debounced the same way but generates no pulse.
- **Control**, evaluated each edge in priority order:
  1. `arst`.
  2. Clear press `p_clr`: `running <= 0`, digits `<= 0`, `tcnt <= 0`. Clear wins over a simultaneous start/stop press and over a simultaneous tick.
  3. Start/stop press `p_ss`: `running <= ~running`.
- **Prescaler** `tcnt` (width `$clog2(TICK_DIV)`):
  - While `running`: counts 0..TICK_DIV-1 and wraps. `tick = running & (tcnt == TICK_DIV-1)`.
  - While stopped: `tcnt` holds, so a paused fraction is preserved on resume.
  - The edge on which `running` toggles uses the old `running` value for tick/`tcnt`.
- **BCD counter**, on `tick`:
  - The tenths digit increments.
  - Each digit 9→0 carries into the next digit.
  - All digits are always 0–9; a non-BCD value is unreachable.
  - 9999→0000 sets `ovf <= 1` for exactly one cycle; counting continues.
- `text` is the digit registers directly (registered output, no combinational path from inputs).

## Timing
- **Reset:** on an edge with `arst = 1`, all of the following are zero after the edge: `text = 16'h0000`, `running = 0`, `ovf = 0`, `tcnt`, `s1`, `s2`, `stb`, `dcnt`.
- **Reset mid-run:** state is lost. A button held through reset is seen as a new press once it has been stable for `DB_CYCLES` (`stb` resets to 0).
- **Press latency:** let edge 1 be the first edge sampling `btn` = 1 with `btn` held.
  - `s2` = 1 after edge 2.
  - `dcnt` reaches `DB_CYCLES-1` after edge `DB_CYCLES+1`.
  - `running`/clear take effect at edge `DB_CYCLES+2`.
- **Bounce:** any return of `s2` to `stb` before `dcnt` reaches `DB_CYCLES-1` restarts the count at 0.
- **Tick spacing:** exactly `TICK_DIV` cycles while running. The first tick after a start from cleared state comes `TICK_DIV` edges after the `running` rise.
- **Overflow:** `ovf` is high for the single cycle following the wrap edge. It is never asserted by clear or reset.

## Test plan
Parameters: `DB_CYCLES = 4`, `TICK_DIV = 5`.
- **Reset:** `arst` = 1 for 1 edge with buttons low → `text = 0x0000`, `running = 0`, `ovf = 0`; these hold with no presses.
- **Start:** `btn_ss` high from edge 1 → `running` = 1 exactly at edge 6. `text` = 0x0001 after edge 11, 0x0002 after edge 16. Holding the button causes no further toggle.
- **Bounce and pause:**
  - `btn_ss` toggles every 2 cycles for 20 cycles → `running` unchanged.
  - Clean release, then a clean press → `running` = 0 and `text` frozen.
  - Resume → the first tick arrives `TICK_DIV` minus the preserved `tcnt` cycles later.
- **Carries:**
  - `text` 0x0099 + tick → 0x0100.
  - 0x0999 + tick → 0x1000.
  - 0x9999 + tick → 0x0000 with `ovf` = 1 for exactly one cycle; `running` stays 1.
- **Clear:**
  - Clear press while running at 0x0123 → `text` = 0x0000 and `running` = 0 on the same edge.
  - `btn_ss` and `btn_clr` pressed on the same edge, with a tick also due → `text` = 0x0000, `running` = 0.
- **Reset mid-run:**
  - `arst` pulse at 0x0042 while running → all outputs zero next edge.
  - With `btn_ss` held through reset → `running` = 1 at edge `DB_CYCLES+2` after reset deasserts.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd
//
// Four-digit BCD stopwatch, 000.0 to 999.9 s, controlled by two push-buttons.
// The digit word feeds the seven-segment display block's text input directly.
//
// Parameters
//   TICK_DIV   clocks per 0.1 s tick (>= 2)
//   DB_CYCLES  clocks a synchronized button level must stay stable before acceptance (>= 2)
//
// Ports
//   i_clk      system clock, all state updates on the rising edge
//   i_arst     synchronous active-high reset
//   i_btn_ss   start/stop button, raw asynchronous level, high = pressed
//   i_btn_clr  clear button, raw asynchronous level, high = pressed
//   o_text     BCD digits {hundreds, tens, units, tenths} of seconds
//   o_running  high while counting
//   o_ovf      one-cycle pulse on the 999.9 -> 000.0 wrap
module stopwatch_bcd #(
  parameter int unsigned TICK_DIV  = 10_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_arst,
  input  logic        i_btn_ss,
  input  logic        i_btn_clr,
  output logic [15:0] o_text,
  output logic        o_running,
  output logic        o_ovf
);

  localparam int unsigned DbW   = $clog2(DB_CYCLES);
  localparam int unsigned TickW = $clog2(TICK_DIV);

  localparam logic [DbW-1:0]   DbMax   = DbW'(DB_CYCLES - 1);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);

  // Button index 0 is start/stop, index 1 is clear.
  localparam int unsigned BtnSs  = 0;
  localparam int unsigned BtnClr = 1;

  // ---------------------------------------------------------------------------
  // Button front end: two-flop synchronizer, debouncer, press detector
  // ---------------------------------------------------------------------------
  logic [1:0]     w_btn;
  logic [1:0]     r_s1;
  logic [1:0]     r_s2;
  logic [1:0]     r_stb;
  logic [DbW-1:0] r_dcnt [2];
  logic [1:0]     w_press;

  assign w_btn = {i_btn_clr, i_btn_ss};

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_stb <= '0;
      for (int i = 0; i < 2; i++) begin
        r_dcnt[i] <= '0;
      end
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_stb[i]) begin
          // Any return to the accepted level restarts the stability count.
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DbMax) begin
          r_stb[i]  <= r_s2[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + DbW'(1);
        end
      end
    end
  end

  // Press pulse fires in the cycle before the stable level rises; releases give no pulse.
  always_comb begin
    w_press = '0;
    for (int i = 0; i < 2; i++) begin
      w_press[i] = r_s2[i] & ~r_stb[i] & (r_dcnt[i] == DbMax);
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and BCD counter
  // ---------------------------------------------------------------------------
  logic             r_running;
  logic [TickW-1:0] r_tcnt;
  logic [15:0]      r_digits;
  logic             r_ovf;
  logic             w_tick;
  logic [15:0]      w_digits_inc;
  logic             w_carry;
  logic             w_wrap;

  // The tick uses the current (pre-toggle) running value.
  assign w_tick = r_running & (r_tcnt == TickMax);

  // Ripple the increment through the digits; a 9 rolls to 0 and passes the carry on.
  always_comb begin
    w_digits_inc = r_digits;
    w_carry      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_digits[4*i +: 4] == 4'd9) begin
          w_digits_inc[4*i +: 4] = 4'd0;
        end else begin
          w_digits_inc[4*i +: 4] = r_digits[4*i +: 4] + 4'd1;
          w_carry                = 1'b0;
        end
      end
    end
  end

  // Carry out of the hundreds digit means 999.9 is rolling over.
  assign w_wrap = w_carry;

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_running <= 1'b0;
      r_tcnt    <= '0;
      r_digits  <= '0;
      r_ovf     <= 1'b0;
    end else if (w_press[BtnClr]) begin
      // Clear beats a simultaneous start/stop press and a simultaneous tick.
      r_running <= 1'b0;
      r_tcnt    <= '0;
      r_digits  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_ovf <= w_tick & w_wrap;
      // While stopped the prescaler holds so a paused fraction survives a resume.
      if (r_running) begin
        r_tcnt <= w_tick ? '0 : r_tcnt + TickW'(1);
      end
      if (w_tick) begin
        r_digits <= w_digits_inc;
      end
      if (w_press[BtnSs]) begin
        r_running <= ~r_running;
      end
    end
  end

  assign o_text    = r_digits;
  assign o_running = r_running;
  assign o_ovf     = r_ovf;

endmodule
